// File: rtl/csr_trap_ctrl.sv
// Trap/mret sequencer that owns the machine-mode CSR write port while a trap or return is in flight.
// Latency: trap writes mepc..mstatus at T+1..T+4 with redirect from T+5; mret writes mstatus at T+1 with redirect from T+2.
// Backpressure: the redirect is held until redirect_ready; pipeline CSR writes are refused whenever the FSM owns the port.
// Ports: commit_* / exc_* / is_mret from commit, *_i current CSR values, pipe_csr_* pipeline write request,
//        csr_* CSR file write port, flush squash pulse, redirect_* fetch handshake, mode current privilege.
module csr_trap_ctrl #(
   parameter int MXLEN = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit_valid,
   input  logic [MXLEN-1:0] commit_pc,
   input  logic             exc_valid,
   input  logic [MXLEN-2:0] exc_code,
   input  logic [MXLEN-1:0] exc_tval,
   input  logic             is_mret,
   output logic             commit_ready,
   input  logic [MXLEN-1:0] mstatus_i,
   input  logic [MXLEN-1:0] mie_i,
   input  logic [MXLEN-1:0] mip_i,
   input  logic [MXLEN-1:0] mtvec_i,
   input  logic [MXLEN-1:0] mepc_i,
   input  logic             pipe_csr_we,
   input  logic [11:0]      pipe_csr_addr,
   input  logic [MXLEN-1:0] pipe_csr_wdata,
   output logic             pipe_csr_ready,
   output logic             csr_we,
   output logic [11:0]      csr_waddr,
   output logic [MXLEN-1:0] csr_wdata,
   output logic             flush,
   output logic             redirect_valid,
   output logic [MXLEN-1:0] redirect_pc,
   input  logic             redirect_ready,
   output logic [1:0]       mode
);

   typedef enum logic [2:0] {
      IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, RET_MSTATUS, REDIRECT
   } state_t;

   localparam logic [1:0] PRV_M = 2'b11;

   state_t           state;
   logic [MXLEN-1:0] l_pc, l_cause, l_tval, l_mstatus, l_mtvec, l_mepc;
   logic             fsm_we;
   logic [11:0]      fsm_addr;
   logic [MXLEN-1:0] fsm_wdata;

   logic             idle, int_take, trap_take, ret_take, accept;
   logic [MXLEN-1:0] pend;
   logic [MXLEN-2:0] int_code;
   logic [MXLEN-1:0] ms_trap, ms_ret, tvec_base, trap_target;

   // Interrupt pick: external > software > timer; global enable only gates M-mode.
   always_comb begin
      pend     = mip_i & mie_i;
      int_take = 1'b0;
      int_code = '0;
      if (pend[11]) begin
         int_take = 1'b1;
         int_code = (MXLEN-1)'(11);
      end else if (pend[3]) begin
         int_take = 1'b1;
         int_code = (MXLEN-1)'(3);
      end else if (pend[7]) begin
         int_take = 1'b1;
         int_code = (MXLEN-1)'(7);
      end
      if (!((mode != PRV_M) || mstatus_i[3]))
         int_take = 1'b0;
   end

   assign idle      = (state == IDLE);
   assign trap_take = idle && commit_valid && (exc_valid || int_take);
   assign ret_take  = idle && commit_valid && !exc_valid && !int_take && is_mret;
   assign accept    = trap_take || ret_take;

   assign commit_ready   = idle;
   assign pipe_csr_ready = idle && !accept;

   // Pass-through only in IDLE; on accept the squashed instruction's write is dropped.
   assign csr_we    = idle ? (pipe_csr_we && !accept) : fsm_we;
   assign csr_waddr = idle ? pipe_csr_addr  : fsm_addr;
   assign csr_wdata = idle ? pipe_csr_wdata : fsm_wdata;

   // Trap entry mstatus: MPIE <= MIE, MIE <= 0, MPP <= current mode.
   always_comb begin
      ms_trap        = l_mstatus;
      ms_trap[7]     = l_mstatus[3];
      ms_trap[3]     = 1'b0;
      ms_trap[12:11] = mode;
   end

   // Return mstatus: MIE <= MPIE, MPIE <= 1, MPP <= U.
   always_comb begin
      ms_ret        = mstatus_i;
      ms_ret[3]     = mstatus_i[7];
      ms_ret[7]     = 1'b1;
      ms_ret[12:11] = 2'b00;
   end

   // Vectored mode only applies to interrupts; the offset wraps at MXLEN bits.
   assign tvec_base   = {l_mtvec[MXLEN-1:2], 2'b00};
   assign trap_target = (l_mtvec[1:0] == 2'b01 && l_cause[MXLEN-1])
                        ? tvec_base + {l_cause[MXLEN-3:0], 2'b00}
                        : tvec_base;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         mode           <= PRV_M;
         flush          <= 1'b0;
         fsm_we         <= 1'b0;
         fsm_addr       <= '0;
         fsm_wdata      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         l_pc           <= '0;
         l_cause        <= '0;
         l_tval         <= '0;
         l_mstatus      <= '0;
         l_mtvec        <= '0;
         l_mepc         <= '0;
      end else begin
         flush <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  l_pc      <= commit_pc;
                  l_cause   <= exc_valid ? {1'b0, exc_code} : {1'b1, int_code};
                  l_tval    <= exc_valid ? exc_tval : '0;
                  l_mstatus <= mstatus_i;
                  l_mtvec   <= mtvec_i;
                  l_mepc    <= mepc_i;
                  flush     <= 1'b1;
                  fsm_we    <= 1'b1;
                  if (trap_take) begin
                     state     <= W_MEPC;
                     fsm_addr  <= 12'h341;
                     fsm_wdata <= commit_pc;
                  end else begin
                     state     <= RET_MSTATUS;
                     fsm_addr  <= 12'h300;
                     fsm_wdata <= ms_ret;
                  end
               end
            end
            W_MEPC: begin
               state     <= W_MCAUSE;
               fsm_addr  <= 12'h342;
               fsm_wdata <= l_cause;
            end
            W_MCAUSE: begin
               state     <= W_MTVAL;
               fsm_addr  <= 12'h343;
               fsm_wdata <= l_tval;
            end
            W_MTVAL: begin
               state     <= W_MSTATUS;
               fsm_addr  <= 12'h300;
               fsm_wdata <= ms_trap;
            end
            W_MSTATUS: begin
               state          <= REDIRECT;
               fsm_we         <= 1'b0;
               mode           <= PRV_M;
               redirect_valid <= 1'b1;
               redirect_pc    <= trap_target;
            end
            RET_MSTATUS: begin
               state          <= REDIRECT;
               fsm_we         <= 1'b0;
               mode           <= l_mstatus[12:11];
               redirect_valid <= 1'b1;
               redirect_pc    <= l_mepc;
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
